ds1302_slave: RTL
=================

Name: ds1302_slave

Overview:
- Synthesizable responder for the DS1302 3-wire serial interface: the chip-side end of the existing DS1302 master controller.
- Decodes the command byte and serves single-byte clock/calendar register reads and writes.
- Holds the register file (second..year, write-protect) and exposes it to the host fabric.
- Used as an on-board RTC stand-in and as the loop-back target for verifying the master.

Parameters:
- SYNC_STAGES, 2, synchronizer depth on ds1302_ce/ds1302_sclk/ds1302_io_in (min 2).
- WP_RESET, 1'b1, reset value of write-protect bit (register 0x8E bit7).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- ds1302_ce  in  1  chip enable from the master.
- ds1302_sclk  in  1  serial clock from the master; each phase is ≥4 clk periods.
- ds1302_io_in  in  1  serial data from the master (the pad input).
- ds1302_io_out  out  1  serial data driven to the master.
- ds1302_io_oe  out  1  pad output enable; 1 = slave drives the pad.
- reg_second, reg_minute, reg_hour, reg_date, reg_month, reg_week, reg_year  out  8 each  current register contents in BCD.
- reg_wp  out  1  write-protect bit.
- wr_strobe  out  1  one-cycle pulse when a register write commits.
- wr_addr  out  3  register index of the last commit: 0=sec … 6=year, 7=WP.
- sec_tick  in  1  one-cycle timekeeping pulse; used only under the optional feature.

Behaviour:
- Reset (synchronous): all reg_* = 8'h00, reg_wp = WP_RESET, ds1302_io_oe = 0, ds1302_io_out = 0, wr_strobe = 0, wr_addr = 0, FSM = S_IDLE.
- Inputs pass through SYNC_STAGES flops. sclk rise/fall events come from the synchronized sclk against its previous value.
- Bit order is LSB first for both command and data.
- Command byte: bit0 = 1 read / 0 write; bits5:1 = address; bit6 = RAM/CK (must be 0); bit7 must be 1.
- Address map (write/read): sec 80/81, min 82/83, hour 84/85, date 86/87, month 88/89, week 8A/8B, year 8C/8D, WP 8E/8F.
- FSM states and transitions:
  - S_IDLE: io_oe = 0. Synchronized ce = 1 → S_CMD with bit counter = 0.
  - S_CMD: shift io on each sclk rise. After the 8th bit:
    - valid write → S_WDATA;
    - valid read → S_RDATA;
    - invalid command (bit7 = 0, bit6 = 1, burst address 0xBE/0xBF, or address > 7) → S_WAIT.
  - S_WDATA: shift 8 bits on sclk rises. After the 8th, commit and pulse wr_strobe for one cycle, then → S_WAIT.
    - When reg_wp = 1, only address 0x8E commits; other writes are dropped and wr_strobe stays 0.
    - The WP register stores bit7 only.
  - S_RDATA:
    - Load the shift register with the addressed value: WP reads as {reg_wp, 7'b0}.
    - Raise io_oe and drive bit0 on the first sclk fall after the 8th command rise. Each later fall presents the next bit.
    - After bit7 has been presented, the next fall → S_WAIT with io_oe = 0.
  - S_WAIT: ignore sclk; io_oe = 0; wait for ce = 0.
- ce = 0 in any state → S_IDLE on the next clk with io_oe = 0. A partial command or partial data is discarded and there is no commit.
- A read presents the register value latched at the 8th command bit. Concurrent host updates (sec_tick) do not corrupt an in-flight read.
- A write commit and sec_tick in the same cycle: the serial write wins for the written register.
- The bit counter is 3 bits plus a done flag, and never wraps into a second byte.

Optional Feature:
- Macro DS1302_SLAVE_TIMEKEEP_EN.
- Defined: each sec_tick increments reg_second in BCD 00→59. On wrap, minute increments (00→59); on wrap, hour increments (00→23, 24-hour mode only) and wraps to 00. No date carry.
  - reg_second bit7 (CH, clock halt) = 1 blocks counting.
- Undefined: sec_tick is ignored; registers change only via serial writes.

Test Plan:
- After reset, read 0x8F → io returns 8'h80 (WP_RESET=1); read 0x81 → 8'h00.
- Write 0x80 ← 8'h45 with WP=1 → wr_strobe stays 0; subsequent read 0x81 returns 8'h00.
- Write 0x8E ← 8'h00, then 0x84 ← 8'h23 → wr_strobe pulses with wr_addr=2; reg_hour = 8'h23; read 0x85 returns 8'h23.
- Drop ce after 5 data bits of write 0x8C ← 8'h24 → reg_year unchanged, io_oe = 0, FSM in S_IDLE; next full transaction succeeds.
- Burst command 0xBF or bit7 = 0 command → io_oe never asserts, no register change.
- With DS1302_SLAVE_TIMEKEEP_EN: hour/min/sec = 23:59:59, one sec_tick → 00:00:00; with sec = 8'h80, sec_tick leaves it unchanged.

Source files
------------

// File: rtl/ds1302_slave_if.sv
// ds1302_slave_if: DS1302 3-wire serial bus (ce, sclk, bidirectional io split into in/out/oe).
// Latency: none, plain wires between the master and the responder.
// Backpressure: none; the master paces the bus, the slave only answers.
interface ds1302_slave_if;
    logic ds1302_ce;
    logic ds1302_sclk;
    logic ds1302_io_in;
    logic ds1302_io_out;
    logic ds1302_io_oe;

    modport master (
        output ds1302_ce,
        output ds1302_sclk,
        output ds1302_io_in,
        input  ds1302_io_out,
        input  ds1302_io_oe
    );

    modport slave (
        input  ds1302_ce,
        input  ds1302_sclk,
        input  ds1302_io_in,
        output ds1302_io_out,
        output ds1302_io_oe
    );
endinterface

// File: rtl/ds1302_slave.sv
// ds1302_slave: DS1302 3-wire responder serving single-byte clock/calendar register reads and writes.
// Latency: SYNC_STAGES+1 clk from a pad edge to the register or pad update it causes.
// Backpressure: none; the master paces every transfer and ce low aborts it without a commit.
// Optional BCD timekeeping on sec_tick is built when DS1302_SLAVE_TIMEKEEP_EN is defined.
module ds1302_slave #(
    parameter int   SYNC_STAGES = 2,
    parameter logic WP_RESET    = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    ds1302_slave_if.slave bus,
    output logic [7:0]    reg_second,
    output logic [7:0]    reg_minute,
    output logic [7:0]    reg_hour,
    output logic [7:0]    reg_date,
    output logic [7:0]    reg_month,
    output logic [7:0]    reg_week,
    output logic [7:0]    reg_year,
    output logic          reg_wp,
    output logic          wr_strobe,
    output logic [2:0]    wr_addr,
    input  logic          sec_tick
);
    typedef enum logic [2:0] {S_IDLE, S_CMD, S_WDATA, S_RDATA, S_WAIT} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] ce_sync, sclk_sync, io_sync;
    logic                   ce_s, sclk_s, io_s, sclk_prev, sclk_rise, sclk_fall;
    logic [2:0]             cnt_q, cnt_d;
    logic                   done_q, done_d;
    logic [7:0]             sh_q, sh_d, shifted, rd_value;
    logic [2:0]             addr_q, addr_d;
    logic                   oe_q, oe_d, out_q, out_d;
    logic                   cmd_ok, commit;

    // Bring the asynchronous pad inputs into the clk domain; keep last sclk for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            ce_sync   <= '0;
            sclk_sync <= '0;
            io_sync   <= '0;
            sclk_prev <= 1'b0;
        end else begin
            ce_sync   <= {ce_sync[SYNC_STAGES-2:0], bus.ds1302_ce};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.ds1302_sclk};
            io_sync   <= {io_sync[SYNC_STAGES-2:0], bus.ds1302_io_in};
            sclk_prev <= sclk_s;
        end
    end

    assign ce_s      = ce_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign io_s      = io_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;

    // Byte as it stands once the current io bit is shifted in (LSB arrives first)
    assign shifted = {io_s, sh_q[7:1]};
    // Clock-register command: bit7 set, RAM/CK clear, address 0..7 (excludes burst 0x1F)
    assign cmd_ok  = shifted[7] & ~shifted[6] & (shifted[5:4] == 2'b00);

    // Read value snapshotted at the 8th command bit, so later host updates cannot tear it
    always_comb begin
        rd_value = 8'h00;
        case (shifted[3:1])
            3'd0:    rd_value = reg_second;
            3'd1:    rd_value = reg_minute;
            3'd2:    rd_value = reg_hour;
            3'd3:    rd_value = reg_date;
            3'd4:    rd_value = reg_month;
            3'd5:    rd_value = reg_week;
            3'd6:    rd_value = reg_year;
            default: rd_value = {reg_wp, 7'b0};
        endcase
    end

    // Transfer FSM next-state: command decode, data shift, read drive; ce low aborts everything
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        sh_d    = sh_q;
        addr_d  = addr_q;
        oe_d    = oe_q;
        out_d   = out_q;
        commit  = 1'b0;
        if (!ce_s) begin
            state_d = S_IDLE;
            cnt_d   = 3'd0;
            done_d  = 1'b0;
            oe_d    = 1'b0;
            out_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_CMD;
                    cnt_d   = 3'd0;
                    done_d  = 1'b0;
                end
                S_CMD: if (sclk_rise) begin
                    sh_d  = shifted;
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        cnt_d  = 3'd0;
                        addr_d = shifted[3:1];
                        if (!cmd_ok) begin
                            state_d = S_WAIT;
                        end else if (shifted[0]) begin
                            state_d = S_RDATA;
                            sh_d    = rd_value;
                        end else begin
                            state_d = S_WDATA;
                        end
                    end
                end
                S_WDATA: if (sclk_rise) begin
                    sh_d  = shifted;
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        cnt_d   = 3'd0;
                        commit  = 1'b1;
                        state_d = S_WAIT;
                    end
                end
                S_RDATA: if (sclk_fall) begin
                    if (done_q) begin
                        state_d = S_WAIT;
                        oe_d    = 1'b0;
                        out_d   = 1'b0;
                        done_d  = 1'b0;
                    end else begin
                        oe_d  = 1'b1;
                        out_d = sh_q[cnt_q];
                        if (cnt_q == 3'd7) done_d = 1'b1;
                        else               cnt_d  = cnt_q + 3'd1;
                    end
                end
                default: begin
                    oe_d  = 1'b0;
                    out_d = 1'b0;
                end
            endcase
        end
    end

    // Transfer FSM state and pad driver registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            done_q  <= 1'b0;
            sh_q    <= 8'h00;
            addr_q  <= 3'd0;
            oe_q    <= 1'b0;
            out_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            sh_q    <= sh_d;
            addr_q  <= addr_d;
            oe_q    <= oe_d;
            out_q   <= out_d;
        end
    end

    assign bus.ds1302_io_oe  = oe_q;
    assign bus.ds1302_io_out = out_q;

`ifdef DS1302_SLAVE_TIMEKEEP_EN
    logic [8:0] sec_inc, min_inc, hr_inc;

    // BCD increment with wrap at top; bit8 is the carry into the next field
    function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
        logic [8:0] r;
        if (v == top)              r = 9'h100;
        else if (v[3:0] == 4'd9)   r = {1'b0, v[7:4] + 4'd1, 4'd0};
        else                       r = {1'b0, v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    assign sec_inc = bcd_inc(reg_second, 8'h59);
    assign min_inc = bcd_inc(reg_minute, 8'h59);
    assign hr_inc  = bcd_inc(reg_hour, 8'h23);
`else
    logic unused_tick;
    assign unused_tick = sec_tick;
`endif

    // Register file: timekeeping first, then a serial commit overrides the register it writes
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_second <= 8'h00;
            reg_minute <= 8'h00;
            reg_hour   <= 8'h00;
            reg_date   <= 8'h00;
            reg_month  <= 8'h00;
            reg_week   <= 8'h00;
            reg_year   <= 8'h00;
            reg_wp     <= WP_RESET;
            wr_strobe  <= 1'b0;
            wr_addr    <= 3'd0;
        end else begin
            wr_strobe <= 1'b0;
`ifdef DS1302_SLAVE_TIMEKEEP_EN
            if (sec_tick && !reg_second[7]) begin
                reg_second <= sec_inc[7:0];
                if (sec_inc[8]) begin
                    reg_minute <= min_inc[7:0];
                    if (min_inc[8]) reg_hour <= hr_inc[7:0];
                end
            end
`endif
            if (commit) begin
                if (addr_q == 3'd7) begin
                    reg_wp    <= shifted[7];
                    wr_strobe <= 1'b1;
                    wr_addr   <= addr_q;
                end else if (!reg_wp) begin
                    case (addr_q)
                        3'd0:    reg_second <= shifted;
                        3'd1:    reg_minute <= shifted;
                        3'd2:    reg_hour   <= shifted;
                        3'd3:    reg_date   <= shifted;
                        3'd4:    reg_month  <= shifted;
                        3'd5:    reg_week   <= shifted;
                        default: reg_year   <= shifted;
                    endcase
                    wr_strobe <= 1'b1;
                    wr_addr   <= addr_q;
                end
            end
        end
    end
endmodule
